imm_decode_queue: RTL and testbench



---
 rtl/imm_decode_queue_pkg.sv | 34 +++
 rtl/imm_decode_queue_immgen.sv | 27 ++
 rtl/imm_decode_queue.sv | 116 +++++++++++
 tb/tb_imm_decode_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_decode_queue_pkg.sv
// Shared opcode constants, immediate-format codes and queue entry layout
// for the decode-front immediate queue.
package imm_decode_queue_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE   = 3'd0,
        I_TYPE_IMM = 3'd1,
        S_TYPE_IMM = 3'd2,
        B_TYPE_IMM = 3'd3,
        U_TYPE_IMM = 3'd4,
        J_TYPE_IMM = 3'd5
    } imm_sel_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        imm_sel_e    sel;
        logic        illegal;
    } q_entry_t;

endpackage

// File: rtl/imm_decode_queue_immgen.sv
// Immediate generator: assembles the sign-extended 32-bit immediate
// for the selected RISC-V instruction format.
module imm_decode_queue_immgen
    import imm_decode_queue_pkg::*;
(
    input  logic [31:0] i_inst,
    input  imm_sel_e    i_sel,
    output logic [31:0] o_imm
);

    always_comb begin
        o_imm = '0;
        unique case (i_sel)
            I_TYPE_IMM: o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
            S_TYPE_IMM: o_imm = {{20{i_inst[31]}}, i_inst[31:25],
                                 i_inst[11:7]};
            B_TYPE_IMM: o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                 i_inst[30:25], i_inst[11:8], 1'b0};
            U_TYPE_IMM: o_imm = {i_inst[31:12], 12'b0};
            J_TYPE_IMM: o_imm = {{11{i_inst[31]}}, i_inst[31],
                                 i_inst[19:12], i_inst[20],
                                 i_inst[30:21], 1'b0};
            default:    o_imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_queue.sv
// Decode-front buffer: classifies opcodes, generates immediates and
// queues decoded instructions toward rename with flush support.
module imm_decode_queue
    import imm_decode_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_imm_sel,
    output logic             out_illegal,
    output logic [CNT_W-1:0] accept_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_accept;
    q_entry_t         r_mem [DEPTH];

    imm_sel_e    w_sel;
    logic        w_illegal;
    logic [31:0] w_imm;
    logic        w_push;
    logic        w_pop;
    q_entry_t    w_head;

    always_comb begin
        w_sel     = IMM_NONE;
        w_illegal = 1'b0;
        unique case (in_inst[6:0])
            OPC_LUI, OPC_AUIPC: w_sel = U_TYPE_IMM;
            OPC_JAL:            w_sel = J_TYPE_IMM;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:
                                w_sel = I_TYPE_IMM;
            OPC_STORE:          w_sel = S_TYPE_IMM;
            OPC_BRANCH:         w_sel = B_TYPE_IMM;
            OPC_OP:             w_sel = IMM_NONE;
            default:            w_illegal = 1'b1;
        endcase
    end

    imm_decode_queue_immgen u_immgen (
        .i_inst (in_inst),
        .i_sel  (w_sel),
        .o_imm  (w_imm)
    );

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_accept <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_accept <= r_accept + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{
                inst:    in_inst,
                pc:      in_pc,
                imm:     w_imm,
                sel:     w_sel,
                illegal: w_illegal
            };
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign out_inst    = out_valid ? w_head.inst    : '0;
    assign out_pc      = out_valid ? w_head.pc      : '0;
    assign out_imm     = out_valid ? w_head.imm     : '0;
    assign out_imm_sel = out_valid ? w_head.sel     : 3'd0;
    assign out_illegal = out_valid ? w_head.illegal : 1'b0;
    assign accept_cnt  = r_accept;

endmodule

// File: tb/tb_imm_decode_queue.sv
// Directed self-checking bench for imm_decode_queue with DEPTH=2.
module tb_imm_decode_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_sel;
    logic        out_illegal;
    logic [31:0] accept_cnt;

    int n_checks;
    int n_fail;

    imm_decode_queue #(.DEPTH(2), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_imm_sel (out_imm_sel),
        .out_illegal (out_illegal),
        .accept_cnt  (accept_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got %0b want 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        n_checks++;
        if (accept_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_accept got %0d want 0", accept_cnt);
        end
        n_checks++;
        if (out_inst !== 32'd0 || out_imm !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bus got inst %h imm %h want 0", out_inst, out_imm);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        offer(32'hFFF00093, 32'h0000_0100);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF ||
            out_imm_sel !== 3'd1 || out_illegal !== 1'b0 ||
            out_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL single_addi got v%0b imm %h sel %0d ill %0b pc %h want v1 imm ffffffff sel 1 ill 0 pc 100",
                     out_valid, out_imm, out_imm_sel, out_illegal, out_pc);
        end
        n_checks++;
        if (accept_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL single_accept got %0d want 1", accept_cnt);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain got %0b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [4];
        logic [31:0] imms  [4];
        logic [2:0]  sels  [4];
        insts = '{32'h00112623, 32'hFE000EE3, 32'h123450B7, 32'h008000EF};
        imms  = '{32'h0000000C, 32'hFFFFFFFC, 32'h12345000, 32'h00000008};
        sels  = '{3'd2, 3'd3, 3'd4, 3'd5};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(insts[i], 32'h200 + 32'(i * 4));
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_inst !== insts[i] ||
                out_imm !== imms[i] || out_imm_sel !== sels[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d got v%0b inst %h imm %h sel %0d want inst %h imm %h sel %0d",
                         i, out_valid, out_inst, out_imm, out_imm_sel,
                         insts[i], imms[i], sels[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || accept_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL b2b_end got v%0b cnt %0d want v0 cnt 5", out_valid, accept_cnt);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(32'h00500093, 32'h300);
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_inst !== 32'h00500093) begin
            n_fail++;
            $display("FAIL bp_first got rdy %0b inst %h want rdy 1 inst 00500093", in_ready, out_inst);
        end
        offer(32'h00600113, 32'h304);
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_inst !== 32'h00500093) begin
            n_fail++;
            $display("FAIL bp_full got rdy %0b inst %h want rdy 0 inst 00500093", in_ready, out_inst);
        end
        offer(32'h00700193, 32'h308);
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_inst !== 32'h00500093 ||
            out_pc !== 32'h300 || accept_cnt !== 32'd7) begin
            n_fail++;
            $display("FAIL bp_hold got rdy %0b inst %h pc %h cnt %0d want rdy 0 inst 00500093 pc 300 cnt 7",
                     in_ready, out_inst, out_pc, accept_cnt);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h00600113 || out_imm !== 32'd6) begin
            n_fail++;
            $display("FAIL bp_second got v%0b inst %h imm %h want inst 00600113 imm 6", out_valid, out_inst, out_imm);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h00700193 || out_imm !== 32'd7) begin
            n_fail++;
            $display("FAIL bp_third got v%0b inst %h imm %h want inst 00700193 imm 7", out_valid, out_inst, out_imm);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || accept_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL bp_end got v%0b cnt %0d want v0 cnt 8", out_valid, accept_cnt);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h00100093, 32'h400);
        tick();
        offer(32'h00200093, 32'h404);
        tick();
        offer(32'h00300093, 32'h408);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_inst !== 32'd0 || accept_cnt !== 32'd10) begin
            n_fail++;
            $display("FAIL flush_state got v%0b rdy %0b inst %h cnt %0d want v0 rdy 1 inst 0 cnt 10",
                     out_valid, in_ready, out_inst, accept_cnt);
        end
        offer(32'h00400093, 32'h40C);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h00400093 || accept_cnt !== 32'd11) begin
            n_fail++;
            $display("FAIL flush_repush got v%0b inst %h cnt %0d want v1 inst 00400093 cnt 11",
                     out_valid, out_inst, accept_cnt);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        offer(32'h0000007F, 32'h500);
        tick();
        n_checks++;
        if (out_illegal !== 1'b1 || out_imm_sel !== 3'd0 || out_imm !== 32'd0) begin
            n_fail++;
            $display("FAIL illegal_opc got ill %0b sel %0d imm %h want ill 1 sel 0 imm 0",
                     out_illegal, out_imm_sel, out_imm);
        end
        offer(32'h002081B3, 32'h504);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b0 ||
            out_imm_sel !== 3'd0 || out_imm !== 32'd0) begin
            n_fail++;
            $display("FAIL op_add got v%0b ill %0b sel %0d imm %h want v1 ill 0 sel 0 imm 0",
                     out_valid, out_illegal, out_imm_sel, out_imm);
        end
        tick();
        n_checks++;
        if (accept_cnt !== 32'd13) begin
            n_fail++;
            $display("FAIL illegal_accept got %0d want 13", accept_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(32'h00100093, 32'h600);
        tick();
        offer(32'h00200093, 32'h604);
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_full got rdy %0b v%0b want rdy 0 v1", in_ready, out_valid);
        end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || accept_cnt !== 32'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_state got v%0b cnt %0d rdy %0b want v0 cnt 0 rdy 1",
                     out_valid, accept_cnt, in_ready);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
